// File: rtl/plab5_mcore_mem_arbiter.sv
// plab5_mcore_mem_arbiter
// Shares one memory request/response port between two requesters. Each
// requester tags its requests with a one-bit security domain. Arbitration is
// round-robin, and only one transaction is in flight at a time. The request
// goes out tagged with the owner's domain. The response goes back only to the
// owner. If the domain memory reports does not match the owner's domain, the
// data field of the response is zeroed and domain_err pulses.
//
// Handshake rule for every val/rdy pair: a transfer happens on the rising
// clock edge where both val and rdy are high. A producer that raises val
// keeps val and msg stable until that transfer. rdy may depend
// combinationally on val (the request grant does).
//
// Message layout (vc mem msg):
//   request  = {type[2:0], opaque, addr, len, data}
//   response = {type[2:0], opaque, len, data}
// Data is always the low data_nbits bits. Nothing else is decoded here.

module plab5_mcore_mem_arbiter #(
  parameter int opaque_nbits  = 8,
  parameter int addr_nbits    = 32,
  parameter int data_nbits    = 128,
  parameter int reqmsg_nbits  = 3 + opaque_nbits + addr_nbits
                                + $clog2(data_nbits/8) + data_nbits,
  parameter int respmsg_nbits = 3 + opaque_nbits
                                + $clog2(data_nbits/8) + data_nbits
)(
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req0_val,
  output logic                     req0_rdy,
  input  logic [reqmsg_nbits-1:0]  req0_msg,
  input  logic                     req0_domain,

  input  logic                     req1_val,
  output logic                     req1_rdy,
  input  logic [reqmsg_nbits-1:0]  req1_msg,
  input  logic                     req1_domain,

  output logic                     resp0_val,
  input  logic                     resp0_rdy,
  output logic [respmsg_nbits-1:0] resp0_msg,

  output logic                     resp1_val,
  input  logic                     resp1_rdy,
  output logic [respmsg_nbits-1:0] resp1_msg,

  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [reqmsg_nbits-1:0]  mem_req_msg,
  output logic                     mem_req_domain,

  input  logic                     mem_resp_val,
  output logic                     mem_resp_rdy,
  input  logic [respmsg_nbits-1:0] mem_resp_msg,
  input  logic                     mem_resp_domain,

  output logic                     domain_err,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                   state;
  logic                     owner;     // port that owns the in-flight transaction
  logic                     prio;      // port favoured when both request
  logic [reqmsg_nbits-1:0]  req_reg;
  logic                     dom_reg;
  logic [respmsg_nbits-1:0] resp_reg;

  logic                     grant_val;
  logic                     grant_port;
  logic [reqmsg_nbits-1:0]  grant_msg;
  logic                     grant_dom;

  logic                     dom_match;
  logic                     owner_rdy;
  logic [respmsg_nbits-1:0] resp_masked;

  // Round-robin grant. It is only offered in IDLE and never while reset is
  // high, so every rdy output is low during reset.
  always_comb begin
    grant_val  = 1'b0;
    grant_port = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_val && req1_val) begin
        grant_val  = 1'b1;
        grant_port = prio;
      end else if (req0_val) begin
        grant_val  = 1'b1;
        grant_port = 1'b0;
      end else if (req1_val) begin
        grant_val  = 1'b1;
        grant_port = 1'b1;
      end
    end
  end

  // Select the granted port's message and domain.
  always_comb begin
    grant_msg = grant_port ? req1_msg    : req0_msg;
    grant_dom = grant_port ? req1_domain : req0_domain;
  end

  // Domain check on the memory response, and the data-scrubbed copy used
  // when the domains disagree.
  always_comb begin
    dom_match   = (mem_resp_domain == dom_reg);
    resp_masked = {mem_resp_msg[respmsg_nbits-1:data_nbits], {data_nbits{1'b0}}};
    owner_rdy   = owner ? resp1_rdy : resp0_rdy;
  end

  // Transaction FSM: grant, forward the request, collect the response,
  // then return it to the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      prio     <= 1'b0;
      req_reg  <= '0;
      dom_reg  <= 1'b0;
      resp_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_val) begin
            req_reg <= grant_msg;
            dom_reg <= grant_dom;
            owner   <= grant_port;
            prio    <= ~grant_port;
            state   <= SEND;
          end
        end
        SEND: begin
          if (mem_req_rdy) state <= WAIT;
        end
        WAIT: begin
          if (mem_resp_val) begin
            resp_reg <= dom_match ? mem_resp_msg : resp_masked;
            state    <= RESP;
          end
        end
        RESP: begin
          if (owner_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Requester-side outputs. Response data goes only to the owner. The
  // other port, and both ports outside RESP, see zeros.
  always_comb begin
    req0_rdy  = grant_val && !grant_port;
    req1_rdy  = grant_val &&  grant_port;
    resp0_val = (state == RESP) && !owner;
    resp1_val = (state == RESP) &&  owner;
    resp0_msg = resp0_val ? resp_reg : '0;
    resp1_msg = resp1_val ? resp_reg : '0;
  end

  // Memory-side outputs. The domain tag is held for the whole transaction.
  // domain_err is high only in the cycle where a mismatching response is
  // captured.
  always_comb begin
    mem_req_val    = (state == SEND);
    mem_req_msg    = (state == SEND) ? req_reg : '0;
    mem_req_domain = (state != IDLE) ? dom_reg : 1'b0;
    mem_resp_rdy   = (state == WAIT);
    domain_err     = (state == WAIT) && mem_resp_val && !dom_match;
    dbg_state      = state;
  end

endmodule

// File: tb/tb_plab5_mcore_mem_arbiter.sv
// Testbench for plab5_mcore_mem_arbiter. Requester and memory drivers generate
// traffic. A negedge monitor runs a transaction-level reference model built
// from the arbitration rules. It pushes the expected memory requests and
// responses into queues and pops them as the DUT presents them.

module tb_plab5_mcore_mem_arbiter;

  localparam int ON = 8;
  localparam int AN = 32;
  localparam int DN = 128;
  localparam int LN = 4;
  localparam int RQ = 3 + ON + AN + LN + DN;   // 175
  localparam int RS = 3 + ON + LN + DN;        // 143

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- DUT signals
  logic          req0_val, req0_rdy, req0_domain;
  logic [RQ-1:0] req0_msg;
  logic          req1_val, req1_rdy, req1_domain;
  logic [RQ-1:0] req1_msg;
  logic          resp0_val, resp0_rdy;
  logic [RS-1:0] resp0_msg;
  logic          resp1_val, resp1_rdy;
  logic [RS-1:0] resp1_msg;
  logic          mem_req_val, mem_req_rdy, mem_req_domain;
  logic [RQ-1:0] mem_req_msg;
  logic          mem_resp_val, mem_resp_rdy, mem_resp_domain;
  logic [RS-1:0] mem_resp_msg;
  logic          domain_err;
  logic [1:0]    dbg_state;

  plab5_mcore_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg), .req0_domain(req0_domain),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg), .req1_domain(req1_domain),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_req_domain(mem_req_domain),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .mem_resp_domain(mem_resp_domain),
    .domain_err(domain_err), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- knobs (main only)
  int          p_req0, p_req1, p_mrdy, p_mresp, p_rrdy, p_flip;
  int          mreq_hold, resp_hold;
  int          quota0 = 0, quota1 = 0;
  int          late_until = 0;
  bit          fix_req_en, fix_mem_en, fix_mem_flip;
  logic [RQ-1:0] fix_req_msg;
  logic          fix_req_dom;
  logic [DN-1:0] fix_mem_data;

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;

  logic [RQ:0]   exp_mem_q[$];      // {domain, msg}
  logic [RS-1:0] exp_q0[$];
  logic [RS-1:0] exp_q1[$];

  bit   m_busy, m_sent, m_got, m_owner, m_dom, m_prio;
  int   grant_log[$];
  int   gcyc_log[$];
  int   done_cnt = 0;
  int   err_pulses = 0;
  int   mreq_hs_cnt = 0;
  logic [RS-1:0] last_resp0, last_resp1;

  // monitor -> driver handshake flags
  bit            hs0, hs1, mreq_hs, mresp_hs;
  logic [RQ-1:0] hs_mem_msg;
  logic          hs_mem_dom;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor / model
  always @(negedge clk) begin
    logic          gv, gp, exp_err;
    logic [RQ:0]   e;
    logic [RS-1:0] er;
    hs0 = 0; hs1 = 0; mreq_hs = 0; mresp_hs = 0;
    if (reset) begin
      exp_mem_q.delete(); exp_q0.delete(); exp_q1.delete();
      grant_log.delete(); gcyc_log.delete();
      m_busy = 0; m_sent = 0; m_got = 0; m_owner = 0; m_dom = 0; m_prio = 0;
    end else begin
      gv = !m_busy && (req0_val || req1_val);
      gp = (req0_val && req1_val) ? m_prio : req1_val;
      chk("req0_rdy", req0_rdy, gv && !gp);
      chk("req1_rdy", req1_rdy, gv && gp);
      chk("mem_req_val", mem_req_val, m_busy && !m_sent);
      chk("mem_req_domain", mem_req_domain, m_busy ? m_dom : 1'b0);
      if (mem_req_val && exp_mem_q.size() > 0)
        chk("mem_req_msg", mem_req_msg, exp_mem_q[0][RQ-1:0]);
      chk("mem_resp_rdy", mem_resp_rdy, m_busy && m_sent && !m_got);
      exp_err = m_busy && m_sent && !m_got && mem_resp_val && (mem_resp_domain != m_dom);
      chk("domain_err", domain_err, exp_err);
      if (domain_err) err_pulses++;
      chk("resp0_val", resp0_val, m_got && !m_owner);
      chk("resp1_val", resp1_val, m_got && m_owner);
      if (resp0_val) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL resp0_unexpected: got %0h expected none at cycle %0d", resp0_msg, cyc);
        end else chk("resp0_msg", resp0_msg, exp_q0[0]);
      end
      if (resp1_val) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL resp1_unexpected: got %0h expected none at cycle %0d", resp1_msg, cyc);
        end else chk("resp1_msg", resp1_msg, exp_q1[0]);
      end

      // advance the reference model by the transfers this cycle completes
      if (gv) begin
        m_busy = 1; m_sent = 0; m_got = 0;
        m_owner = gp;
        m_dom   = gp ? req1_domain : req0_domain;
        m_prio  = !gp;
        exp_mem_q.push_back({m_dom, gp ? req1_msg : req0_msg});
        grant_log.push_back(int'(gp));
        gcyc_log.push_back(cyc);
        if (gp) hs1 = 1; else hs0 = 1;
      end else if (m_busy && !m_sent && mem_req_rdy) begin
        m_sent = 1;
        e = exp_mem_q.pop_front();
        hs_mem_msg = e[RQ-1:0];
        hs_mem_dom = e[RQ];
        mreq_hs = 1;
        mreq_hs_cnt++;
      end else if (m_busy && m_sent && !m_got && mem_resp_val) begin
        m_got = 1;
        if (mem_resp_domain == m_dom) er = mem_resp_msg;
        else er = {mem_resp_msg[RS-1:DN], {DN{1'b0}}};
        if (m_owner) exp_q1.push_back(er); else exp_q0.push_back(er);
        mresp_hs = 1;
      end else if (m_got && (m_owner ? resp1_rdy : resp0_rdy)) begin
        if (m_owner) begin
          last_resp1 = resp1_msg;
          if (exp_q1.size() > 0) void'(exp_q1.pop_front());
        end else begin
          last_resp0 = resp0_msg;
          if (exp_q0.size() > 0) void'(exp_q0.pop_front());
        end
        m_busy = 0; m_got = 0;
        done_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  function automatic logic [RQ-1:0] rand_req();
    logic [DN-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    return {3'($urandom_range(0, 7)), 8'($urandom), 32'($urandom), 4'($urandom), d};
  endfunction

  int  issued0 = 0, issued1 = 0;
  bit  mem_pend;
  int  mreq_age, rage0, rage1;

  initial begin
    req0_val = 0; req0_msg = '0; req0_domain = 0;
    req1_val = 0; req1_msg = '0; req1_domain = 0;
    resp0_rdy = 0; resp1_rdy = 0;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_msg = '0; mem_resp_domain = 0;
    mem_pend = 0; mreq_age = 0; rage0 = 0; rage1 = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        req0_val = 0; req1_val = 0; mem_resp_val = 0; mem_pend = 0;
        mem_req_rdy = 0; resp0_rdy = 0; resp1_rdy = 0;
        mreq_age = 0; rage0 = 0; rage1 = 0;
      end else begin
        // requesters: keep val until the transfer, then maybe issue again
        if (hs0) req0_val = 0;
        if (hs1) req1_val = 0;
        if (!req0_val && issued0 < quota0 && $urandom_range(0, 99) < p_req0) begin
          req0_msg    = fix_req_en ? fix_req_msg : rand_req();
          req0_domain = fix_req_en ? fix_req_dom : 1'($urandom);
          req0_val    = 1; issued0++;
        end
        if (!req1_val && issued1 < quota1 && $urandom_range(0, 99) < p_req1) begin
          req1_msg    = fix_req_en ? fix_req_msg : rand_req();
          req1_domain = fix_req_en ? fix_req_dom : 1'($urandom);
          req1_val    = 1; issued1++;
        end
        // memory: reply to the request it accepted, copying type/opaque/len
        if (mresp_hs) begin mem_pend = 0; mem_resp_val = 0; end
        if (mreq_hs) begin
          mem_pend = 1;
          mem_resp_msg = {hs_mem_msg[RQ-1:RQ-11], hs_mem_msg[DN+3:DN],
                          fix_mem_en ? fix_mem_data : {$urandom, $urandom, $urandom, $urandom}};
          mem_resp_domain = hs_mem_dom ^ (fix_mem_en ? fix_mem_flip : ($urandom_range(0, 99) < p_flip));
        end
        if (mem_pend) begin
          if (!mem_resp_val && $urandom_range(0, 99) < p_mresp) mem_resp_val = 1;
        end else if (cyc < late_until) begin
          mem_resp_val = 1;
          mem_resp_msg = {$urandom, $urandom, $urandom, $urandom, $urandom};
          mem_resp_domain = 1'($urandom);
        end else begin
          mem_resp_val = 0;
        end
        if (mem_req_val) begin
          mem_req_rdy = (mreq_age >= mreq_hold) && ($urandom_range(0, 99) < p_mrdy);
          mreq_age++;
        end else begin
          mreq_age = 0; mem_req_rdy = ($urandom_range(0, 99) < p_mrdy);
        end
        // response consumers
        if (resp0_val) begin
          resp0_rdy = (rage0 >= resp_hold) && ($urandom_range(0, 99) < p_rrdy); rage0++;
        end else begin
          rage0 = 0; resp0_rdy = ($urandom_range(0, 99) < p_rrdy);
        end
        if (resp1_val) begin
          resp1_rdy = (rage1 >= resp_hold) && ($urandom_range(0, 99) < p_rrdy); rage1++;
        end else begin
          rage1 = 0; resp1_rdy = ($urandom_range(0, 99) < p_rrdy);
        end
      end
    end
  end

  // ---------------------------------------------------------------- main sequence
  task automatic zero_wait();
    p_req0 = 100; p_req1 = 100; p_mrdy = 100; p_mresp = 100; p_rrdy = 100;
    p_flip = 0; mreq_hold = 0; resp_hold = 0;
    fix_req_en = 0; fix_mem_en = 0; fix_mem_flip = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req0_rdy"}, req0_rdy, 1'b0);
    chk({tag, "_req1_rdy"}, req1_rdy, 1'b0);
    chk({tag, "_resp0_val"}, resp0_val, 1'b0);
    chk({tag, "_resp1_val"}, resp1_val, 1'b0);
    chk({tag, "_resp0_msg"}, resp0_msg, '0);
    chk({tag, "_resp1_msg"}, resp1_msg, '0);
    chk({tag, "_mem_req_val"}, mem_req_val, 1'b0);
    chk({tag, "_mem_req_msg"}, mem_req_msg, '0);
    chk({tag, "_mem_req_domain"}, mem_req_domain, 1'b0);
    chk({tag, "_mem_resp_rdy"}, mem_resp_rdy, 1'b0);
    chk({tag, "_domain_err"}, domain_err, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 reset = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #3 reset = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    target = done_cnt + n;
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    chk("wait_done", done_cnt >= target, 1'b1);
  endtask

  initial begin
    int n, c0;
    logic [10:0] exp_to;
    zero_wait();
    fix_req_msg = '0; fix_req_dom = 0; fix_mem_data = '0;
    reset = 1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #3 reset = 0;

    // single request from port 0, secure read at 0x1000
    fix_req_en = 1; fix_req_msg = {3'd0, 8'h11, 32'h1000, 4'd0, 128'd0}; fix_req_dom = 1;
    fix_mem_en = 1; fix_mem_data = 128'hDEADBEEF; fix_mem_flip = 0;
    quota0 += 1;
    wait_done(1, 200);
    chk("single_grant", grant_log[0], 0);
    chk("single_data", last_resp0[DN-1:0], 128'hDEADBEEF);

    // contention from reset: grants alternate starting with port 0
    zero_wait();
    do_reset();
    quota0 += 2; quota1 += 2;
    wait_done(4, 400);
    for (int i = 0; i < 4; i++) chk("contention_order", grant_log[i], i % 2);

    // backpressure: memory stalls 5 cycles, requester stalls 3 cycles
    n = grant_log.size();
    mreq_hold = 5; resp_hold = 3;
    quota0 += 1; quota1 += 1;
    wait_done(2, 400);
    chk("bp_first", grant_log[n], 0);
    chk("bp_second", grant_log[n+1], 1);
    chk("bp_gap", gcyc_log[n+1] - gcyc_log[n], 12);
    zero_wait();

    // domain mismatch on port 1
    n = err_pulses;
    fix_req_en = 1; fix_req_msg = {3'd1, 8'hC3, 32'h2040, 4'd0, 128'd0}; fix_req_dom = 0;
    fix_mem_en = 1; fix_mem_data = 128'h12345678; fix_mem_flip = 1;
    quota1 += 1;
    wait_done(1, 200);
    exp_to = {3'd1, 8'hC3};
    chk("mismatch_data", last_resp1[DN-1:0], '0);
    chk("mismatch_type_opaque", last_resp1[RS-1:DN+4], exp_to);
    chk("mismatch_err_pulses", err_pulses - n, 1);
    zero_wait();

    // reset while waiting for memory, then a late memory response
    p_mresp = 0;
    c0 = mreq_hs_cnt;
    quota0 += 1;
    for (int i = 0; i < 200 && mreq_hs_cnt == c0; i++) @(negedge clk);
    chk("reach_wait", mreq_hs_cnt != c0, 1'b1);
    @(posedge clk); #3 reset = 1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    @(posedge clk); #3 reset = 0;
    p_mresp = 100;
    late_until = cyc + 4;
    repeat (6) @(negedge clk);
    quota0 += 1; quota1 += 1;
    wait_done(2, 400);
    chk("post_reset_grant0", grant_log[0], 0);
    chk("post_reset_grant1", grant_log[1], 1);

    // lone requester on port 1, three back-to-back transactions
    n = grant_log.size();
    quota1 += 3;
    wait_done(3, 400);
    for (int i = 0; i < 3; i++) chk("lone_port", grant_log[n+i], 1);
    chk("lone_gap1", gcyc_log[n+1] - gcyc_log[n], 4);
    chk("lone_gap2", gcyc_log[n+2] - gcyc_log[n+1], 4);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      p_req0 = $urandom_range(20, 100); p_req1 = $urandom_range(20, 100);
      p_mrdy = $urandom_range(20, 100); p_mresp = $urandom_range(20, 100);
      p_rrdy = $urandom_range(20, 100); p_flip = 30;
      mreq_hold = $urandom_range(0, 2); resp_hold = $urandom_range(0, 2);
      quota0 += 15; quota1 += 15;
      wait_done(30, 20000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time limit
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/plab5_mcore_mem_arbiter.md
Name: plab5_mcore_mem_arbiter

Overview:
- Shares one memory request/response port between two requesters (port 0, port 1) on the memory side of the proc-to-mem translation path.
- Each requester carries a one-bit security domain with every request.
- Round-robin arbitration, one transaction in flight at a time.
- Tags the outgoing request with the owner's domain and returns the response only to the owning requester, with domain-checked data.

Parameters:
- opaque_nbits, 8, opaque field width (o)
- addr_nbits, 32, address width (a)
- data_nbits, 128, memory data width (md)
- reqmsg_nbits, VC_MEM_REQ_MSG_NBITS(o,a,md), request message width
- respmsg_nbits, VC_MEM_RESP_MSG_NBITS(o,md), response message width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req0_val / req1_val  in  1  requester request valid
- req0_rdy / req1_rdy  out  1  arbiter accepts request
- req0_msg / req1_msg  in  reqmsg_nbits  request message
- req0_domain / req1_domain  in  1  requester security domain (0 = normal, 1 = secure)
- resp0_val / resp1_val  out  1  response valid to requester
- resp0_rdy / resp1_rdy  in  1  requester accepts response
- resp0_msg / resp1_msg  out  respmsg_nbits  response message
- mem_req_val  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_msg  out  reqmsg_nbits  registered request
- mem_req_domain  out  1  domain of the in-flight transaction
- mem_resp_val  in  1  memory response valid
- mem_resp_rdy  out  1  arbiter accepts response
- mem_resp_msg  in  respmsg_nbits  memory response
- mem_resp_domain  in  1  domain tagged on the response by memory
- domain_err  out  1  one-cycle pulse on a domain mismatch

Behaviour:
- FSM states: IDLE, SEND, WAIT, RESP.
- Registers:
  - owner: 1 bit
  - prio: 1 bit, the port favoured next
  - req_reg: reqmsg_nbits
  - dom_reg: 1 bit
  - resp_reg: respmsg_nbits
- Reset (async, immediate): state = IDLE, prio = 0, owner = 0, dom_reg = 0, req_reg = 0, resp_reg = 0. All val/rdy outputs are 0, domain_err = 0, and all msg outputs are 0.
- Reset mid-transaction drops the transaction silently. No response is delivered afterwards.
- IDLE:
  - reqN_rdy = 1 only for the granted port; at most one rdy is high.
  - Grant rules:
    - If only one reqN_val is high, that port is granted.
    - If both are high, port prio is granted.
    - If none are high, there is no grant.
  - On the grant handshake: latch req_reg, dom_reg = reqN_domain, owner = N, prio = ~N. Go to SEND.
- SEND:
  - mem_req_val = 1, mem_req_msg = req_reg, mem_req_domain = dom_reg.
  - When mem_req_rdy is high, go to WAIT.
  - Earliest request-to-memory latency is 1 cycle after acceptance.
- WAIT:
  - mem_resp_rdy = 1.
  - When mem_resp_val is high, capture into resp_reg and go to RESP.
  - If mem_resp_domain == dom_reg, resp_reg = mem_resp_msg.
  - Otherwise:
    - resp_reg = mem_resp_msg with bits [data_nbits-1:0] forced to 0;
    - domain_err pulses high in the capture cycle.
- RESP:
  - respOwner_val = 1, respOwner_msg = resp_reg.
  - The other port's val stays 0.
  - When respOwner_rdy is high, go to IDLE.
  - The next grant occurs no earlier than the following cycle.
- mem_req_domain is held at dom_reg in SEND, WAIT and RESP. It is 0 in IDLE.
- reqN_rdy is 0 in all states except IDLE.
- mem_resp_rdy is 0 outside WAIT.
- A mem_resp_val arriving in SEND or RESP is not accepted.
- Minimum transaction length is 4 cycles with zero-wait memory and requester.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1. A lone requester may be granted back-to-back.
- Message fields pass through unchanged. The arbiter does not decode type, opaque or len.

Test Plan:
- Single request: req0_val with domain=1, type=read, addr=0x1000. With mem_req_rdy=1 and a 1-cycle memory response (domain=1, data=0xDEADBEEF), the required results are:
  - mem_req_val rises 1 cycle after acceptance with mem_req_domain=1;
  - resp0_val carries 0xDEADBEEF;
  - resp1_val stays 0.
- Contention: req0_val and req1_val held high for 4 transactions from reset. Grant order must be 0,1,0,1, with each response returned only to its owner and opaque fields preserved.
- Backpressure: mem_req_rdy=0 for 5 cycles, then resp0_rdy=0 for 3 cycles.
  - mem_req_msg stays stable while waiting;
  - resp0_msg stays stable while waiting;
  - no new grant occurs until the resp handshake completes.
- Domain mismatch: port 1 request with domain=0, memory replies with domain=1 and data=0x12345678. Required results:
  - resp1 data field is 0;
  - type and opaque are intact;
  - domain_err pulses for exactly 1 cycle.
- Reset in WAIT: assert reset asynchronously, then deassert.
  - All outputs go to 0 immediately;
  - prio = 0;
  - a late mem_resp_val is ignored;
  - the next simultaneous request grants port 0.
- Lone requester: only req1_val, 3 back-to-back transactions. All three are granted to port 1 without stall cycles beyond the 4-cycle minimum.
